// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register with direct hold/shift/load modes and an SPI-style burst serialiser.
// Optional build macro SHIFT_REG_NEGEDGE_EN moves every register update to the falling edge of clk.
module shift_reg_universal #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdin,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] shr, shl;

    assign shr = {sin_r, q_q[WIDTH-1:1]};
    assign shl = {q_q[WIDTH-2:0], sin_l};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;   // done is a single-cycle pulse, cleared even when en=0
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = BURST;
                        q_d     = pdin;
                        dir_d   = dir;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        case (mode)
                            2'b01:   q_d = shr;
                            2'b10:   q_d = shl;
                            2'b11:   q_d = pdin;
                            default: q_d = q_q;
                        endcase
                    end
                end
                BURST: begin
                    q_d   = dir_q ? shl : shr;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef SHIFT_REG_NEGEDGE_EN
    always_ff @(negedge clk or posedge reset) begin
`else
    always_ff @(posedge clk or posedge reset) begin
`endif
        if (reset) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q       = q_q;
    assign sout_r  = q_q[0];
    assign sout_l  = q_q[WIDTH-1];
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_cnt = cnt_q;

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised WIDTH-bit universal register; successor to the single-bit D flip-flop.
- Supports hold, shift right, shift left and parallel load in direct mode.
- Adds a burst controller: loads a word, then shifts it out serially over WIDTH shifts while capturing serial input, in the style of an SPI shift engine.
- Used as the datapath storage and serialiser element for serial links in the design.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  clock; active edge is rising unless the optional feature is enabled.
- reset  input  1  reset, asynchronous, active-high.
- en  input  1  clock enable for all register, counter and state updates; en=0 freezes everything except reset.
- mode  input  2  direct-mode operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input; enters q[WIDTH-1] on a right shift.
- sin_l  input  1  serial input; enters q[0] on a left shift.
- pdin  input  WIDTH  parallel load data.
- start  input  1  burst request; sampled in IDLE only.
- dir  input  1  burst direction, sampled with start: 0 right, 1 left.
- q  output  WIDTH  register contents.
- sout_r  output  1  q[0], combinational from q.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse marking burst completion.
- bit_cnt  output  $clog2(WIDTH+1)  shifts completed in the current burst.

Behaviour:
- Reset values: q=RESET_VAL, state IDLE, busy=0, done=0, bit_cnt=0. Reset has priority over every other input.
- Direct-mode operations, applied on each active edge with en=1 in IDLE:
  - Shift right: q <= {sin_r, q[WIDTH-1:1]}.
  - Shift left: q <= {q[WIDTH-2:0], sin_l}.
  - Load: q <= pdin.
  - Hold: q unchanged.
- Latency: one edge from input to q.
- States: IDLE and BURST, stored in registered state.
- IDLE -> BURST: en=1 and start=1.
  - Action on that edge: q <= pdin, latch dir, bit_cnt <= 0, busy <= 1.
  - start has priority over mode; mode is ignored on that edge.
- BURST, each edge with en=1:
  - Shift in the latched direction, using sin_r or sin_l.
  - bit_cnt <= bit_cnt + 1.
- BURST, en=0: q, bit_cnt and the latched dir hold; this is a stall.
- BURST ignores mode, start and dir.
- BURST -> IDLE on the edge that performs shift number WIDTH:
  - busy <= 0, done <= 1, bit_cnt <= WIDTH.
  - On the next edge done <= 0, irrespective of en.
- Serial timing:
  - For a right burst, sout_r presents pdin[0], pdin[1], ..., pdin[WIDTH-1] in the cycle before each of the WIDTH shifts.
  - For a left burst, sout_l presents pdin[WIDTH-1] down to pdin[0] in the same way.
- Received data: after the burst, q holds the captured serial bits. The first bit captured ends in q[0] for a right burst and in q[WIDTH-1] for a left burst.
- bit_cnt holds WIDTH in IDLE until the next start.
- start while busy=1 is ignored; no queueing.
- start on the same edge that done is set is ignored, because the state is still BURST. A new burst can be accepted from the following edge.
- Reset mid-burst: immediate return to reset values. No done pulse is produced.
- X on mode while in BURST has no effect on q.

Optional Feature:
- Macro: SHIFT_REG_NEGEDGE_EN.
- Defined: all state, q, bit_cnt, busy and done update on the falling edge of clk. Reset stays asynchronous, active-high.
- Undefined: all updates occur on the rising edge.
- Functional behaviour is otherwise identical in both builds.

Test Plan:
- Reset: assert reset mid-cycle with RESET_VAL=0x00, WIDTH=8 -> q=0x00, busy=0, done=0, bit_cnt=0 immediately, without a clock edge.
- Load and shift: load 0xA5, then shift right with sin_r=1 -> q=0xD2. Reload 0xA5, then shift left with sin_l=0 -> q=0x4A.
- Hold and enable: load 0x3C, then apply mode=01 for 3 edges with en=0 -> q remains 0x3C. Apply mode=00 with en=1 -> q remains 0x3C.
- Right burst: start with dir=0, pdin=0x96; feed sin_r with 0x3C LSB-first. Expected:
  - sout_r sequence 0,1,1,0,1,0,0,1.
  - done pulses exactly 8 edges after the start edge.
  - Final q=0x3C, bit_cnt=8.
- Stall and ignore: during a left burst, drop en for 2 cycles at bit_cnt=3 and pulse start again -> bit_cnt holds at 3, the burst completes after 8 enabled shifts, only one done pulse occurs, and the second start is ignored.
- Reset mid-burst: assert reset at bit_cnt=5 -> q=RESET_VAL, busy=0, no done pulse. A fresh burst after deassertion completes normally.
